sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SIZE, default 22, sprite edge in pixels (2..63).
REQ-002 SHALL have parameter COORD_W, default 9, screen coordinate width.
REQ-003 SHALL have parameter FRAMES, default 4, animation frames held in sprite ROM (power of two).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock.
REQ-005 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have: enable  in  1  clock-enable for all state except reset.
REQ-007 SHALL have: draw  in  1  request, sampled while idle.
REQ-008 SHALL have: x, y  in  COORD_W each  new top-left position.
REQ-009 SHALL have: direction  in  2  rotation 0/90/180/270 degrees clockwise.
REQ-010 SHALL have: frame  in  clog2(FRAMES)  animation frame.
REQ-011 SHALL have: fg_color, bg_color  in  24 each  {R,G,B} bytes.
REQ-012 SHALL have: rom_addr  out  clog2(FRAMES*SIZE*SIZE); rom_data  in  1  mask bit, valid one cycle after rom_addr.
REQ-013 SHALL have: tft_busy  in  1; tft_transmit  out  1; tft_dc  out  1 (0 command, 1 data); tft_data  out  8.
REQ-014 SHALL have: busy  out  1  high from accepted draw until completion.

Function
REQ-015 States IDLE, WIN (11 window bytes), FETCH (ROM wait), PIX (3 bytes/pixel), NEXT_PASS; all transitions gated by enable.
REQ-016 In IDLE with draw=1: latch x, y, direction, frame; busy=1 next cycle; draw while busy SHALL be ignored.
REQ-017 Byte handshake: a byte is issued only when tft_busy=0 and tft_transmit=0; tft_transmit is a single-cycle pulse, dropped the following cycle.
REQ-018 WIN sequence: 0x2A, xmin[8], xmin[7:0], xmax[8], xmax[7:0], 0x2B, ymin[8], ymin[7:0], ymax[8], ymax[7:0], 0x2C; dc=0 on the three commands, 1 otherwise; upper byte zero-padded.
REQ-019 Pixels raster order, x fastest; each pixel three data bytes R, G, B.
REQ-020 Source mapping for output (px,py): dir0 (px,py); dir1 (py,SIZE-1-px); dir2 (SIZE-1-px,SIZE-1-py); dir3 (SIZE-1-py,px); rom_addr = frame*SIZE*SIZE + sy*SIZE + sx.
REQ-021 Sprite pass: mask 1 -> fg_color, mask 0 -> bg_color; window [x, x+SIZE-1] x [y, y+SIZE-1].
REQ-022 Erase pass (all bytes bg_color) precedes sprite pass, covering only uncovered old area: pure vertical move down -> rows old_y..y-1; up -> rows y+SIZE..old_y+SIZE-1; horizontal analogous; diagonal move or |delta| >= SIZE -> whole old square; no move -> no erase pass.
REQ-023 Coordinate arithmetic SHALL be COORD_W bits, wrap-around modulo 2^COORD_W, no saturation.
REQ-024 After last byte of sprite pass: old position <= latched x,y; busy=0; return to IDLE.
REQ-025 First draw after reset SHALL skip erase (old position invalid).

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, tft_transmit=0, tft_dc=0, tft_data=0, rom_addr=0, old position invalid, regardless of enable or mid-transfer state.
REQ-027 A transfer aborted by reset SHALL NOT resume; next draw starts with WIN.

Configuration
REQ-028 Macro SPRITE_BLITTER_ERASE_EN: defined -> erase pass per REQ-022; undefined -> no erase logic, sprite pass only, REQ-022/025 void.

Verification
REQ-029 Reset, draw x=5,y=5,dir0,frame0 -> 11 WIN bytes 2A,00,05,00,1A,2B,00,05,00,1A,2C then 1452 data bytes, busy low after.
REQ-030 Then draw x=5,y=8 (ERASE_EN) -> erase window y 5..7, 198 bg bytes, then full sprite window y 8..29.
REQ-031 Then draw x=40,y=40 -> erase whole old square 5..26 x 8..29 before sprite.
REQ-032 Single mask bit at (sx=21,sy=0), dir1 -> only pixel (px=21,py=21) fg; dir2 -> (0,21).
REQ-033 tft_busy held high 50 cycles mid-pixel -> no tft_transmit pulses, byte order intact after release; draw pulses during busy ignored.
REQ-034 rst_n low mid-PIX -> outputs zero asynchronously; next draw emits 0x2A first, no erase.

Source files
------------

// File: rtl/sprite_blitter.sv
`default_nettype none
// sprite_blitter: streams a rotated, animated 1-bpp sprite to a TFT over a byte-wide command/data port.
// Define SPRITE_BLITTER_ERASE_EN to erase the uncovered part of the previous sprite before each draw.
module sprite_blitter #(
  parameter int SIZE    = 22,
  parameter int COORD_W = 9,
  parameter int FRAMES  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic                                  draw,
  input  logic [COORD_W-1:0]                    x,
  input  logic [COORD_W-1:0]                    y,
  input  logic [1:0]                            direction,
  input  logic [$clog2(FRAMES)-1:0]             frame,
  input  logic [23:0]                           fg_color,
  input  logic [23:0]                           bg_color,
  output logic [$clog2(FRAMES*SIZE*SIZE)-1:0]   rom_addr,
  input  logic                                  rom_data,
  input  logic                                  tft_busy,
  output logic                                  tft_transmit,
  output logic                                  tft_dc,
  output logic [7:0]                            tft_data,
  output logic                                  busy
);
  localparam int FRAME_W = $clog2(FRAMES);
  localparam int ADDR_W  = $clog2(FRAMES*SIZE*SIZE);
  localparam int CNT_W   = 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE-1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WIN   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_PIX   = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  logic [2:0]         state;
  logic [COORD_W-1:0] x_l, y_l, win_x, win_y, win_xmax, win_ymax;
  logic [1:0]         dir_l;
  logic [FRAME_W-1:0] frame_l;
  logic [CNT_W-1:0]   win_w, win_h, px, py, sx, sy;
  logic [3:0]         idx;
  logic [1:0]         sub;
  logic               erase_pass, mask, can_send, win_dc;
  logic [7:0]         win_byte, pix_byte;
  logic [23:0]        pix_color;
  logic [15:0]        x0_e, x1_e, y0_e, y1_e;
  logic [ADDR_W-1:0]  src_addr;
  logic               er_need;
  logic [COORD_W-1:0] er_x, er_y;
  logic [CNT_W-1:0]   er_w, er_h;

  assign can_send = !tft_busy && !tft_transmit;

  // Window bounds wrap in COORD_W bits before being zero-extended into the two bytes sent.
  assign win_xmax = win_x + COORD_W'(win_w) - COORD_W'(1);
  assign win_ymax = win_y + COORD_W'(win_h) - COORD_W'(1);
  assign x0_e = 16'(win_x);
  assign x1_e = 16'(win_xmax);
  assign y0_e = 16'(win_y);
  assign y1_e = 16'(win_ymax);

  always_comb begin
    win_byte = 8'h00;
    win_dc   = 1'b1;
    case (idx)
      4'd0:    begin win_byte = 8'h2A; win_dc = 1'b0; end
      4'd1:    win_byte = x0_e[15:8];
      4'd2:    win_byte = x0_e[7:0];
      4'd3:    win_byte = x1_e[15:8];
      4'd4:    win_byte = x1_e[7:0];
      4'd5:    begin win_byte = 8'h2B; win_dc = 1'b0; end
      4'd6:    win_byte = y0_e[15:8];
      4'd7:    win_byte = y0_e[7:0];
      4'd8:    win_byte = y1_e[15:8];
      4'd9:    win_byte = y1_e[7:0];
      4'd10:   begin win_byte = 8'h2C; win_dc = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    sx = px;
    sy = py;
    case (dir_l)
      2'd1:    begin sx = py;        sy = LAST - px; end
      2'd2:    begin sx = LAST - px; sy = LAST - py; end
      2'd3:    begin sx = LAST - py; sy = px;        end
      default: ;
    endcase
  end

  assign src_addr  = ADDR_W'(frame_l) * ADDR_W'(SIZE*SIZE) + ADDR_W'(sy) * ADDR_W'(SIZE) + ADDR_W'(sx);
  assign pix_color = (erase_pass || !mask) ? bg_color : fg_color;
  assign pix_byte  = (sub == 2'd0) ? pix_color[23:16] : (sub == 2'd1) ? pix_color[15:8] : pix_color[7:0];

`ifdef SPRITE_BLITTER_ERASE_EN
  logic [COORD_W-1:0] old_x, old_y, dx, dy, adx, ady;
  logic               old_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      old_valid <= 1'b0;
      old_x     <= '0;
      old_y     <= '0;
    end else if (enable && state == ST_NEXT && !erase_pass) begin
      old_valid <= 1'b1;
      old_x     <= x_l;
      old_y     <= y_l;
    end
  end

  assign dx  = x - old_x;
  assign dy  = y - old_y;
  assign adx = dx[COORD_W-1] ? -dx : dx;
  assign ady = dy[COORD_W-1] ? -dy : dy;

  // Short axis-aligned moves erase only the uncovered strip; anything else erases the whole old square.
  always_comb begin
    er_need = old_valid && (dx != '0 || dy != '0);
    er_x    = old_x;
    er_y    = old_y;
    er_w    = CNT_W'(SIZE);
    er_h    = CNT_W'(SIZE);
    if (dx == '0 && ady < COORD_W'(SIZE)) begin
      er_h = CNT_W'(ady);
      if (dy[COORD_W-1]) er_y = y + COORD_W'(SIZE);
    end else if (dy == '0 && adx < COORD_W'(SIZE)) begin
      er_w = CNT_W'(adx);
      if (dx[COORD_W-1]) er_x = x + COORD_W'(SIZE);
    end
  end
`else
  assign er_need = 1'b0;
  assign er_x    = '0;
  assign er_y    = '0;
  assign er_w    = '0;
  assign er_h    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;   busy <= 1'b0;      tft_transmit <= 1'b0;
      tft_dc <= 1'b0;     tft_data <= 8'h00; rom_addr <= '0;
      x_l <= '0;  y_l <= '0;  dir_l <= '0;  frame_l <= '0;
      win_x <= '0; win_y <= '0; win_w <= '0; win_h <= '0;
      px <= '0;   py <= '0;   idx <= '0;   sub <= '0;
      erase_pass <= 1'b0; mask <= 1'b0;
    end else begin
      // The strobe always falls after one cycle so a paused enable cannot repeat a byte.
      tft_transmit <= 1'b0;
      if (enable) begin
        case (state)
          ST_IDLE: if (draw) begin
            x_l <= x; y_l <= y; dir_l <= direction; frame_l <= frame;
            busy <= 1'b1;
            idx  <= '0;
            erase_pass <= er_need;
            win_x <= er_need ? er_x : x;
            win_y <= er_need ? er_y : y;
            win_w <= er_need ? er_w : CNT_W'(SIZE);
            win_h <= er_need ? er_h : CNT_W'(SIZE);
            state <= ST_WIN;
          end
          ST_WIN: if (can_send) begin
            tft_transmit <= 1'b1;
            tft_data     <= win_byte;
            tft_dc       <= win_dc;
            if (idx == 4'd10) begin
              idx <= '0; px <= '0; py <= '0; sub <= '0;
              state <= ST_FETCH;
            end else begin
              idx <= idx + 4'd1;
            end
          end
          ST_FETCH: begin
            sub <= sub + 2'd1;
            if (sub == 2'd0) rom_addr <= src_addr;
            if (sub == 2'd2) begin
              mask  <= rom_data;
              sub   <= '0;
              state <= ST_PIX;
            end
          end
          ST_PIX: if (can_send) begin
            tft_transmit <= 1'b1;
            tft_data     <= pix_byte;
            tft_dc       <= 1'b1;
            if (sub == 2'd2) begin
              sub <= '0;
              if (px == win_w - CNT_W'(1)) begin
                px <= '0;
                if (py == win_h - CNT_W'(1)) begin
                  state <= ST_NEXT;
                end else begin
                  py    <= py + CNT_W'(1);
                  state <= ST_FETCH;
                end
              end else begin
                px    <= px + CNT_W'(1);
                state <= ST_FETCH;
              end
            end else begin
              sub <= sub + 2'd1;
            end
          end
          ST_NEXT: if (erase_pass) begin
            erase_pass <= 1'b0;
            win_x <= x_l; win_y <= y_l;
            win_w <= CNT_W'(SIZE); win_h <= CNT_W'(SIZE);
            idx   <= '0;
            state <= ST_WIN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// Bench for sprite_blitter: expected TFT bytes are queued at stimulus time and popped by a negedge monitor.
module tb_sprite_blitter;
  localparam int SIZE   = 22;
  localparam int FRAMES = 4;
  localparam int NPIX   = SIZE*SIZE;
  localparam logic [23:0] FG = 24'hF1E2D3;
  localparam logic [23:0] BG = 24'h102030;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, draw = 1'b0, tft_busy = 1'b0;
  logic        rom_data = 1'b0;
  logic [8:0]  x = '0, y = '0;
  logic [1:0]  direction = '0, frame = '0;
  logic [10:0] rom_addr;
  logic        tft_transmit, tft_dc, busy;
  logic [7:0]  tft_data;

  bit          rom [0:FRAMES*NPIX-1];
  logic [8:0]  q[$];
  int          n_tests = 0, n_fail = 0, bytes_seen = 0;
`ifdef SPRITE_BLITTER_ERASE_EN
  int          old_x = 0, old_y = 0;
  bit          old_valid = 1'b0;
`endif

  sprite_blitter #(.SIZE(SIZE), .COORD_W(9), .FRAMES(FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .draw(draw), .x(x), .y(y),
    .direction(direction), .frame(frame), .fg_color(FG), .bg_color(BG),
    .rom_addr(rom_addr), .rom_data(rom_data), .tft_busy(tft_busy),
    .tft_transmit(tft_transmit), .tft_dc(tft_dc), .tft_data(tft_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= (int'(rom_addr) < FRAMES*NPIX) ? rom[rom_addr] : 1'b0;

  always @(negedge clk) begin
    logic [8:0] exp_b;
    if (rst_n && tft_transmit) begin
      bytes_seen++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL byte_unexpected #%0d actual dc=%0b data=%02h required none", bytes_seen, tft_dc, tft_data);
      end else begin
        exp_b = q.pop_front();
        if ({tft_dc, tft_data} !== exp_b) begin
          n_fail++;
          $display("FAIL byte #%0d actual dc=%0b data=%02h required dc=%0b data=%02h",
                   bytes_seen, tft_dc, tft_data, exp_b[8], exp_b[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int wrap(input int v);
    return v & 511;
  endfunction

  task automatic push_byte(input bit dc, input logic [7:0] b);
    q.push_back({dc, b});
  endtask

  task automatic push_color(input bit on);
    logic [23:0] c;
    c = on ? FG : BG;
    push_byte(1'b1, c[23:16]); push_byte(1'b1, c[15:8]); push_byte(1'b1, c[7:0]);
  endtask

  task automatic push_win(input int x0, input int y0, input int w, input int h);
    int x1, y1;
    x1 = wrap(x0 + w - 1);
    y1 = wrap(y0 + h - 1);
    push_byte(1'b0, 8'h2A);
    push_byte(1'b1, 8'(x0 >> 8)); push_byte(1'b1, 8'(x0)); push_byte(1'b1, 8'(x1 >> 8)); push_byte(1'b1, 8'(x1));
    push_byte(1'b0, 8'h2B);
    push_byte(1'b1, 8'(y0 >> 8)); push_byte(1'b1, 8'(y0)); push_byte(1'b1, 8'(y1 >> 8)); push_byte(1'b1, 8'(y1));
    push_byte(1'b0, 8'h2C);
  endtask

  task automatic push_sprite(input int d, input int f);
    for (int py = 0; py < SIZE; py++) begin
      for (int px = 0; px < SIZE; px++) begin
        int sx, sy;
        case (d)
          1:       begin sx = py;          sy = SIZE - 1 - px; end
          2:       begin sx = SIZE - 1 - px; sy = SIZE - 1 - py; end
          3:       begin sx = SIZE - 1 - py; sy = px;          end
          default: begin sx = px;          sy = py;          end
        endcase
        push_color(rom[f*NPIX + sy*SIZE + sx]);
      end
    end
  endtask

  // Sprite at (40,40) in frame 3 whose only set pixel lands at raster index fg_idx.
  task automatic push_single(input int fg_idx);
    push_win(40, 40, SIZE, SIZE);
    for (int i = 0; i < NPIX; i++) push_color(i == fg_idx);
  endtask

`ifdef SPRITE_BLITTER_ERASE_EN
  function automatic int sdelta(input int a, input int b);
    int t;
    t = (a - b) & 511;
    return (t >= 256) ? t - 512 : t;
  endfunction

  task automatic push_erase(input int x0, input int y0, input int w, input int h);
    push_win(x0, y0, w, h);
    repeat (w*h) push_color(1'b0);
  endtask
`endif

  task automatic expect_draw(input int nx, input int ny, input int d, input int f);
`ifdef SPRITE_BLITTER_ERASE_EN
    if (old_valid) begin
      int dx, dy;
      dx = sdelta(nx, old_x);
      dy = sdelta(ny, old_y);
      if (dx != 0 || dy != 0) begin
        if (dx == 0 && dy > 0 && dy < SIZE)       push_erase(old_x, old_y, SIZE, dy);
        else if (dx == 0 && dy < 0 && -dy < SIZE) push_erase(old_x, wrap(ny + SIZE), SIZE, -dy);
        else if (dy == 0 && dx > 0 && dx < SIZE)  push_erase(old_x, old_y, dx, SIZE);
        else if (dy == 0 && dx < 0 && -dx < SIZE) push_erase(wrap(nx + SIZE), old_y, -dx, SIZE);
        else                                      push_erase(old_x, old_y, SIZE, SIZE);
      end
    end
    old_x = nx; old_y = ny; old_valid = 1'b1;
`endif
    push_win(nx, ny, SIZE, SIZE);
    push_sprite(d, f);
  endtask

  task automatic launch(input int nx, input int ny, input int d, input int f);
    @(negedge clk);
    x = 9'(nx); y = 9'(ny); direction = 2'(d); frame = 2'(f); draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    check("busy_after_draw", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int start, input int exp_bytes);
    int cyc;
    cyc = 0;
    while (busy && cyc < 12000) begin @(negedge clk); cyc++; end
    check({name, "_finished_in_time"}, {31'd0, (cyc < 12000)}, 32'd1);
    repeat (2) @(negedge clk);
    check({name, "_byte_count"}, bytes_seen - start, exp_bytes);
    check({name, "_queue_drained"}, q.size(), 32'd0);
    check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_bytes(input string name, input int n);
    int cyc;
    cyc = 0;
    while (bytes_seen < n && cyc < 5000) begin @(negedge clk); cyc++; end
    check({name, "_progress"}, {31'd0, (bytes_seen >= n)}, 32'd1);
  endtask

  // Freeze the transfer either via enable or via tft_busy, and poke draw meanwhile.
  task automatic pause(input string name, input bit use_en, input int cyc);
    int pulses;
    pulses = 0;
    @(negedge clk);
    if (use_en) enable = 1'b0; else tft_busy = 1'b1;
    x = 9'd200; y = 9'd200; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (tft_transmit) pulses++;
    end
    check({name, "_no_transmit"}, pulses, 32'd0);
    check({name, "_busy_held"}, {31'd0, busy}, 32'd1);
    enable = 1'b1; tft_busy = 1'b0;
  endtask

  int e2, e3, e6, e7;
  logic [8:0] first_win [11] = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h11A,
                                 9'h02B, 9'h100, 9'h105, 9'h100, 9'h11A, 9'h02C};

  initial begin
    int start;
    for (int i = 0; i < FRAMES*NPIX; i++) rom[i] = (((i*37) + (i/5)) % 3) == 0;
`ifdef SPRITE_BLITTER_ERASE_EN
    e2 = 1672; e3 = 2926; e6 = 1672; e7 = 2926;
`else
    e2 = 1463; e3 = 1463; e6 = 1463; e7 = 1463;
`endif
    #23;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_transmit", {31'd0, tft_transmit}, 32'd0);
    check("rst_dc", {31'd0, tft_dc}, 32'd0);
    check("rst_data", {24'd0, tft_data}, 32'd0);
    check("rst_rom_addr", {21'd0, rom_addr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (first_win[i]) q.push_back(first_win[i]);
    push_sprite(0, 0);
`ifdef SPRITE_BLITTER_ERASE_EN
    old_x = 5; old_y = 5; old_valid = 1'b1;
`endif
    start = bytes_seen; launch(5, 5, 0, 0); wait_done("draw1", start, 1463);

    expect_draw(5, 8, 0, 1);
    start = bytes_seen; launch(5, 8, 0, 1);
    wait_bytes("draw2", start + 300);
    pause("enable_pause", 1'b1, 20);
    wait_done("draw2", start, e2);

    expect_draw(40, 40, 2, 2);
    start = bytes_seen; launch(40, 40, 2, 2); wait_done("draw3", start, e3);

    for (int i = 3*NPIX; i < 4*NPIX; i++) rom[i] = 1'b0;
    rom[3*NPIX + 21] = 1'b1;
    push_single(21*SIZE + 21);
    start = bytes_seen; launch(40, 40, 1, 3); wait_done("single_dir1", start, 1463);
    push_single(21*SIZE + 0);
    start = bytes_seen; launch(40, 40, 2, 3); wait_done("single_dir2", start, 1463);

    expect_draw(37, 40, 3, 0);
    start = bytes_seen; launch(37, 40, 3, 0); wait_done("draw_left", start, e6);

    expect_draw(500, 100, 0, 1);
    start = bytes_seen; launch(500, 100, 0, 1); wait_done("draw_wrap", start, e7);

    expect_draw(500, 100, 1, 2);
    start = bytes_seen; launch(500, 100, 1, 2);
    wait_bytes("stall", start + 500);
    pause("tft_busy_stall", 1'b0, 50);
    wait_done("stall", start, 1463);

    expect_draw(20, 20, 0, 0);
    start = bytes_seen; launch(20, 20, 0, 0);
    wait_bytes("abort", start + 60);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_transmit", {31'd0, tft_transmit}, 32'd0);
    check("abort_dc", {31'd0, tft_dc}, 32'd0);
    check("abort_data", {24'd0, tft_data}, 32'd0);
    check("abort_rom_addr", {21'd0, rom_addr}, 32'd0);
    q.delete();
`ifdef SPRITE_BLITTER_ERASE_EN
    old_valid = 1'b0;
`endif
    @(negedge clk) rst_n = 1'b1;
    expect_draw(30, 30, 2, 3);
    start = bytes_seen; launch(30, 30, 2, 3); wait_done("after_reset", start, 1463);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
